// File: rtl/eth_header_tx.sv
// Ethernet frame transmitter: preamble, SFD, destination MAC, source MAC,
// type/length, then a streamed payload with zero padding to the minimum
// length, followed by a fixed inter-frame gap. The data/control byte stream
// has the same shape the receive-side header parser consumes.
module eth_header_tx #(
  parameter logic [47:0] DST_ADDR    = 48'h010203040506,
  parameter logic [47:0] SRC_ADDR    = 48'hFFFEFDFCFBFA,
  parameter logic [15:0] TYPE_LENGTH = 16'h0800,
  parameter int          MIN_PAYLOAD = 46,
  parameter int          MAX_PAYLOAD = 1500,
  parameter int          IFG_CYCLES  = 12
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  input  logic [7:0] payload_data,
  input  logic       payload_valid,
  input  logic       payload_last,
  output logic       payload_ready,
  output logic [7:0] data,
  output logic       control,
  output logic       preamble_sent,
  output logic       dst_addr_sent,
  output logic       src_addr_sent,
  output logic       type_length_sent,
  output logic       underrun
);

  // Field-level constants.
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [2:0]  PREAMBLE_LAST = 3'd5;  // 6 more 55s after the first
  localparam logic [2:0]  ADDR_LAST     = 3'd5;  // 6 bytes per MAC address
  localparam logic [10:0] MIN_CNT       = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_CNT       = 11'(MAX_PAYLOAD);
  localparam int          IFG_W         = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

  // Each state names the field whose byte the next clock edge emits.
  typedef enum logic [3:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_PAD,
    S_IFG
  } state_t;

  state_t           state_q,     state_d;
  logic [2:0]       field_cnt_q, field_cnt_d;   // byte index within header field
  logic [10:0]      pay_cnt_q,   pay_cnt_d;     // payload + pad bytes sent
  logic [IFG_W-1:0] ifg_cnt_q,   ifg_cnt_d;
  logic [7:0]       data_q,      data_d;
  logic             control_q,   control_d;
  logic             busy_q,      busy_d;
  logic             pre_sent_q,  pre_sent_d;
  logic             dst_sent_q,  dst_sent_d;
  logic             src_sent_q,  src_sent_d;
  logic             type_sent_q, type_sent_d;
  logic             underrun_q,  underrun_d;

  // Byte selection: shift the field so the byte due next sits at the MS end.
  logic [47:0] dst_shift;
  logic [47:0] src_shift;
  logic [15:0] type_shift;
  logic [10:0] pay_inc;
  logic        payload_end;

  assign dst_shift   = DST_ADDR << {field_cnt_q, 3'b000};
  assign src_shift   = SRC_ADDR << {field_cnt_q, 3'b000};
  assign type_shift  = TYPE_LENGTH << {field_cnt_q[0], 3'b000};
  assign pay_inc     = pay_cnt_q + 11'd1;
  // Payload closes on an accepted last byte or on hitting the truncation count.
  assign payload_end = payload_last || (pay_inc == MAX_CNT);

  // Ready is a pure state decode so it never depends on payload_valid.
  assign payload_ready = (state_q == S_PAYLOAD);

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // variable unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    field_cnt_d = field_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    busy_d      = busy_q;
    data_d      = 8'h00;
    control_d   = 1'b0;
    pre_sent_d  = 1'b0;
    dst_sent_d  = 1'b0;
    src_sent_d  = 1'b0;
    type_sent_d = 1'b0;
    underrun_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d = start;
        if (start) begin
          data_d      = PREAMBLE_BYTE;
          control_d   = 1'b1;
          field_cnt_d = 3'd0;
          state_d     = S_PREAMBLE;
        end
      end

      S_PREAMBLE: begin
        data_d    = PREAMBLE_BYTE;
        control_d = 1'b1;
        if (field_cnt_q == PREAMBLE_LAST) begin
          field_cnt_d = 3'd0;
          state_d     = S_SFD;
        end else begin
          field_cnt_d = field_cnt_q + 3'd1;
        end
      end

      S_SFD: begin
        data_d      = SFD_BYTE;
        control_d   = 1'b1;
        pre_sent_d  = 1'b1;
        field_cnt_d = 3'd0;
        state_d     = S_DST;
      end

      S_DST: begin
        data_d    = dst_shift[47:40];
        control_d = 1'b1;
        if (field_cnt_q == ADDR_LAST) begin
          dst_sent_d  = 1'b1;
          field_cnt_d = 3'd0;
          state_d     = S_SRC;
        end else begin
          field_cnt_d = field_cnt_q + 3'd1;
        end
      end

      S_SRC: begin
        data_d    = src_shift[47:40];
        control_d = 1'b1;
        if (field_cnt_q == ADDR_LAST) begin
          src_sent_d  = 1'b1;
          field_cnt_d = 3'd0;
          state_d     = S_TYPE;
        end else begin
          field_cnt_d = field_cnt_q + 3'd1;
        end
      end

      S_TYPE: begin
        data_d    = type_shift[15:8];
        control_d = 1'b1;
        if (field_cnt_q[0]) begin
          type_sent_d = 1'b1;
          field_cnt_d = 3'd0;
          pay_cnt_d   = 11'd0;
          state_d     = S_PAYLOAD;
        end else begin
          field_cnt_d = field_cnt_q + 3'd1;
        end
      end

      S_PAYLOAD: begin
        if (payload_valid) begin
          data_d    = payload_data;
          control_d = 1'b1;
          pay_cnt_d = pay_inc;
          if (payload_end) begin
            ifg_cnt_d = '0;
            state_d   = (pay_inc < MIN_CNT) ? S_PAD : S_IFG;
          end
        end else begin
          // Starvation aborts the frame: no pad, straight into the gap.
          underrun_d = 1'b1;
          ifg_cnt_d  = '0;
          state_d    = S_IFG;
        end
      end

      S_PAD: begin
        control_d = 1'b1;
        pay_cnt_d = pay_inc;
        if (pay_inc >= MIN_CNT) begin
          ifg_cnt_d = '0;
          state_d   = S_IFG;
        end
      end

      S_IFG: begin
        // busy stays high here; it falls on the IDLE edge that follows.
        if (ifg_cnt_q == IFG_LAST) begin
          state_d = S_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all registered outputs; reset drops any frame in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      field_cnt_q <= 3'd0;
      pay_cnt_q   <= 11'd0;
      ifg_cnt_q   <= '0;
      busy_q      <= 1'b0;
      data_q      <= 8'h00;
      control_q   <= 1'b0;
      pre_sent_q  <= 1'b0;
      dst_sent_q  <= 1'b0;
      src_sent_q  <= 1'b0;
      type_sent_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q     <= state_d;
      field_cnt_q <= field_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      control_q   <= control_d;
      pre_sent_q  <= pre_sent_d;
      dst_sent_q  <= dst_sent_d;
      src_sent_q  <= src_sent_d;
      type_sent_q <= type_sent_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy             = busy_q;
  assign data             = data_q;
  assign control          = control_q;
  assign preamble_sent    = pre_sent_q;
  assign dst_addr_sent    = dst_sent_q;
  assign src_addr_sent    = src_sent_q;
  assign type_length_sent = type_sent_q;
  assign underrun         = underrun_q;

endmodule
